// File: rtl/uart_pkg.sv
// Shared constants and types for the UART command path.
// Holds the command bytes, default reply bytes, the clock/baud divider and
// the responder state encoding, so receiver, transmitter and responder agree.
package uart_pkg;

  // Host command bytes
  localparam logic [7:0] CMD_W = 8'h57;  // 'W' : write, addr, data
  localparam logic [7:0] CMD_R = 8'h52;  // 'R' : read, addr

  // Default reply bytes
  localparam logic [7:0] ACK_DEFAULT = 8'h4B;  // 'K'
  localparam logic [7:0] NAK_DEFAULT = 8'h3F;  // '?'

  // Bit-period divider shared with the receiver and transmitter
  localparam int unsigned CLK_HZ = 24_000_000;
  localparam int unsigned BAUD   = 115_200;
  localparam int unsigned DIV    = CLK_HZ / BAUD;

  // Responder FSM states
  typedef enum logic [3:0] {
    ST_IDLE       = 4'd0,
    ST_GET_ADDR   = 4'd1,
    ST_GET_DATA   = 4'd2,
    ST_DO_WRITE   = 4'd3,
    ST_DO_READ    = 4'd4,
    ST_LATCH_RD   = 4'd5,
    ST_TX_START   = 4'd6,
    ST_TX_WAIT_HI = 4'd7,
    ST_TX_WAIT_LO = 4'd8
  } cmd_state_e;

  // True for a byte that opens a multi-byte frame
  function automatic logic is_cmd(input logic [7:0] b);
    return (b == CMD_W) || (b == CMD_R);
  endfunction

endpackage

// File: rtl/uart_cmd_slave.sv
// Purpose : parse host command frames from the UART receiver, perform register
//           writes/reads and answer every complete frame with one reply byte.
// Latency : write reply start 2 cycles after the data byte, read 3, NAK 1.
// Backpressure: waits for tx_busy low before tx_start; bytes arriving while a
//           reply is in progress are dropped and flagged in sticky overrun.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   rx_data, rx_ready   received byte and its valid level (rising edge = new byte)
//   tx_data, tx_start   reply byte (held through the transmission), 1-cycle request
//   tx_busy             transmitter busy, rises the cycle after an accepted start
//   reg_addr, reg_wdata register address / write data (registered)
//   reg_we, reg_re      one-cycle write / read strobes
//   reg_rdata           read data, valid the cycle after reg_re
//   overrun             sticky: a byte arrived while a reply was in progress
module uart_cmd_slave
  import uart_pkg::*;
#(
  parameter int unsigned TIMEOUT = 2400000,
  parameter logic [7:0]  ACK     = ACK_DEFAULT,
  parameter logic [7:0]  NAK     = NAK_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_ready,
  output logic [7:0] tx_data,
  output logic       tx_start,
  input  logic       tx_busy,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  output logic       reg_re,
  input  logic [7:0] reg_rdata,
  output logic       overrun
);

  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  cmd_state_e state_q, state_d;

  logic             rx_prev_q;
  logic             busy_q;
  logic             is_wr_q,     is_wr_d;
  logic [CNT_W-1:0] cnt_q,       cnt_d;
  logic [7:0]       tx_data_q,   tx_data_d;
  logic [7:0]       reg_addr_q,  reg_addr_d;
  logic [7:0]       reg_wdata_q, reg_wdata_d;
  logic             overrun_q,   overrun_d;

  logic byte_ev;
  logic in_frame;
  logic in_reply;
  logic expire;

  // A new byte is the rising edge of the receiver's valid level.
  assign byte_ev  = rx_ready & ~rx_prev_q;

  // Collecting the address or data byte of a frame: the timeout runs here.
  assign in_frame = (state_q == ST_GET_ADDR) || (state_q == ST_GET_DATA);

  // Register access or reply in flight: incoming bytes cannot be taken.
  assign in_reply = (state_q != ST_IDLE) && !in_frame;

  // A byte arriving in the expiry cycle takes priority over the timeout.
  assign expire   = in_frame && (cnt_q == CNT_LAST) && !byte_ev;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (byte_ev) begin
          state_d = is_cmd(rx_data) ? ST_GET_ADDR : ST_TX_START;
        end
      end
      ST_GET_ADDR: begin
        if (byte_ev) begin
          state_d = is_wr_q ? ST_GET_DATA : ST_DO_READ;
        end else if (expire) begin
          state_d = ST_IDLE;
        end
      end
      ST_GET_DATA: begin
        if (byte_ev) begin
          state_d = ST_DO_WRITE;
        end else if (expire) begin
          state_d = ST_IDLE;
        end
      end
      ST_DO_WRITE:   state_d = ST_TX_START;
      ST_DO_READ:    state_d = ST_LATCH_RD;
      ST_LATCH_RD:   state_d = ST_TX_START;
      // Leaves together with the start pulse, which needs an idle transmitter.
      ST_TX_START: begin
        if (!busy_q) begin
          state_d = ST_TX_WAIT_HI;
        end
      end
      ST_TX_WAIT_HI: begin
        if (tx_busy) begin
          state_d = ST_TX_WAIT_LO;
        end
      end
      ST_TX_WAIT_LO: begin
        if (!tx_busy) begin
          state_d = ST_IDLE;
        end
      end
      default:       state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs (Moore decodes of state and registered busy only)
  // ---------------------------------------------------------------------------
  // busy_q is a registered copy of tx_busy. It lags by one cycle, which is
  // safe: the transmitter only turns busy in response to our own start pulse,
  // and after that pulse the FSM has already left TX_START. After a reset the
  // earliest TX_START is two cycles out, by which time busy_q reflects a
  // transmission still finishing from before the reset.
  always_comb begin
    tx_start = 1'b0;
    reg_we   = 1'b0;
    reg_re   = 1'b0;
    case (state_q)
      ST_DO_WRITE: reg_we   = 1'b1;
      ST_DO_READ:  reg_re   = 1'b1;
      ST_TX_START: tx_start = ~busy_q;
      default:     ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Frame fields, reply byte, overrun flag and inter-byte timeout
  // ---------------------------------------------------------------------------
  always_comb begin
    is_wr_d     = is_wr_q;
    reg_addr_d  = reg_addr_q;
    reg_wdata_d = reg_wdata_q;
    tx_data_d   = tx_data_q;
    overrun_d   = overrun_q;
    cnt_d       = '0;

    case (state_q)
      ST_IDLE: begin
        if (byte_ev) begin
          is_wr_d = (rx_data == CMD_W);
          if (!is_cmd(rx_data)) begin
            tx_data_d = NAK;
          end
        end
      end
      ST_GET_ADDR: begin
        if (byte_ev) begin
          reg_addr_d = rx_data;
        end
      end
      ST_GET_DATA: begin
        if (byte_ev) begin
          reg_wdata_d = rx_data;
        end
      end
      ST_DO_WRITE: tx_data_d = ACK;
      // reg_rdata is valid in the cycle after the read strobe, i.e. here.
      ST_LATCH_RD: tx_data_d = reg_rdata;
      default:     ;
    endcase

    if (byte_ev && in_reply) begin
      overrun_d = 1'b1;
    end

    // Counter runs only while waiting for the next byte of a frame; it is
    // cleared on the expiry cycle so it never reaches TIMEOUT and cannot wrap.
    if (in_frame && !byte_ev && !expire) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_prev_q   <= 1'b0;
      busy_q      <= 1'b0;
      is_wr_q     <= 1'b0;
      cnt_q       <= '0;
      tx_data_q   <= 8'hFF;
      reg_addr_q  <= 8'h00;
      reg_wdata_q <= 8'h00;
      overrun_q   <= 1'b0;
    end else begin
      rx_prev_q   <= rx_ready;
      busy_q      <= tx_busy;
      is_wr_q     <= is_wr_d;
      cnt_q       <= cnt_d;
      tx_data_q   <= tx_data_d;
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
      overrun_q   <= overrun_d;
    end
  end

  assign tx_data   = tx_data_q;
  assign reg_addr  = reg_addr_q;
  assign reg_wdata = reg_wdata_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_cmd_slave.sv
// Bench for uart_cmd_slave: drives host frames, models the transmitter and a
// 256-byte register file, and checks replies, strobes and timing against a
// frame-level reference (expected register contents plus reply rules).
module tb_uart_cmd_slave;

  localparam int TO     = 50;  // inter-byte timeout used for the DUT
  localparam int TX_LEN = 40;  // transmitter busy length (10 bits x 4 clocks)

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_ready = 1'b0;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy = 1'b0;
  logic [7:0] reg_addr, reg_wdata;
  logic       reg_we, reg_re;
  logic [7:0] reg_rdata = 8'h00;
  logic       overrun;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int last_ev = 0;

  logic [7:0] exp_mem [256];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_cmd_slave #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_we(reg_we), .reg_re(reg_re),
    .reg_rdata(reg_rdata), .overrun(overrun)
  );

  // Transmitter model: not reset by rst, finishes any byte on its own.
  int         tx_cnt = 0;
  logic [7:0] txq[$];
  logic [7:0] tx_cur = 8'h00;
  logic       tx_track = 1'b0;
  always @(posedge clk) begin
    if (tx_busy) begin
      if (tx_cnt == 0) tx_busy <= 1'b0;
      else tx_cnt <= tx_cnt - 1;
    end else if (tx_start) begin
      tx_busy  <= 1'b1;
      tx_cnt   <= TX_LEN - 1;
      tx_cur   <= tx_data;
      tx_track <= 1'b1;
      txq.push_back(tx_data);
    end
    if (rst) tx_track <= 1'b0;
  end

  // Register file model
  bit [7:0] mem [256];
  always @(posedge clk) begin
    if (reg_we) mem[reg_addr] <= reg_wdata;
    if (reg_re) reg_rdata <= mem[reg_addr];
  end

  // Strobe monitor, sampled mid-cycle
  logic [15:0] wq[$];
  logic [7:0]  rq[$];
  int we_cyc = -1, re_cyc = -1, st_cyc = -1, viol = 0;
  always @(negedge clk) begin
    if (reg_we) begin wq.push_back({reg_addr, reg_wdata}); we_cyc = cyc; end
    if (reg_re) begin rq.push_back(reg_addr); re_cyc = cyc; end
    if (tx_start) begin st_cyc = cyc; if (tx_busy) viol++; end
    if (tx_busy && tx_track && !rst && tx_data !== tx_cur) viol++;
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int hold);
    rx_data  = b;
    rx_ready = 1'b1;
    last_ev  = cyc;
    repeat (hold) step();
    rx_ready = 1'b0;
    step();
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) step();
  endtask

  task automatic wait_done(input int nt);
    int i = 0;
    while (!(txq.size() > nt && !tx_busy) && i < 3000) begin step(); i++; end
    checks++;
    if (i >= 3000) begin errors++; $display("FAIL reply_wait: got no finished reply within 3000 cycles, want one"); end
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    checks++; if (tx_data !== 8'hFF)  begin errors++; $display("FAIL rst_tx_data: got %h want ff", tx_data); end
    checks++; if (reg_addr !== 8'h00) begin errors++; $display("FAIL rst_reg_addr: got %h want 00", reg_addr); end
    checks++; if (reg_wdata !== 8'h00) begin errors++; $display("FAIL rst_reg_wdata: got %h want 00", reg_wdata); end
    checks++; if (tx_start !== 1'b0)  begin errors++; $display("FAIL rst_tx_start: got %b want 0", tx_start); end
    checks++; if (reg_we !== 1'b0)    begin errors++; $display("FAIL rst_reg_we: got %b want 0", reg_we); end
    checks++; if (reg_re !== 1'b0)    begin errors++; $display("FAIL rst_reg_re: got %b want 0", reg_re); end
    checks++; if (overrun !== 1'b0)   begin errors++; $display("FAIL rst_overrun: got %b want 0", overrun); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_write();
    int nw = wq.size(), nt = txq.size(), e;
    send_byte(8'h57, 1); send_byte(8'h05, 1); send_byte(8'hA3, 1);
    e = last_ev;
    wait_done(nt);
    exp_mem[8'h05] = 8'hA3;
    checks++; if (wq.size() != nw + 1) begin errors++; $display("FAIL write_count: got %0d want 1", wq.size() - nw); end
    else begin checks++; if (wq[nw] !== 16'h05A3) begin errors++; $display("FAIL write_addr_data: got %h want 05a3", wq[nw]); end end
    checks++; if (txq.size() != nt + 1 || txq[nt] !== 8'h4B) begin errors++; $display("FAIL write_reply: got %0d bytes want one 4b", txq.size() - nt); end
    checks++; if (we_cyc != e + 1) begin errors++; $display("FAIL write_we_lat: got %0d want %0d", we_cyc - e, 1); end
    checks++; if (st_cyc != e + 2) begin errors++; $display("FAIL write_start_lat: got %0d want %0d", st_cyc - e, 2); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL write_overrun: got %b want 0", overrun); end
  endtask

  task automatic test_read();
    int nw = wq.size(), nr = rq.size(), nt = txq.size(), e;
    send_byte(8'h52, 1); send_byte(8'h05, 1);
    e = last_ev;
    wait_done(nt);
    checks++; if (rq.size() != nr + 1 || rq[nr] !== 8'h05) begin errors++; $display("FAIL read_strobe: got %0d reads want one at 05", rq.size() - nr); end
    checks++; if (txq.size() != nt + 1 || txq[nt] !== exp_mem[8'h05]) begin errors++; $display("FAIL read_reply: got %0d bytes want one %h", txq.size() - nt, exp_mem[8'h05]); end
    checks++; if (wq.size() != nw) begin errors++; $display("FAIL read_no_write: got %0d writes want 0", wq.size() - nw); end
    checks++; if (re_cyc != e + 1) begin errors++; $display("FAIL read_re_lat: got %0d want 1", re_cyc - e); end
    checks++; if (st_cyc != e + 3) begin errors++; $display("FAIL read_start_lat: got %0d want 3", st_cyc - e); end
  endtask

  task automatic test_unknown();
    int nw = wq.size(), nr = rq.size(), nt = txq.size(), e;
    send_byte(8'h00, 1);
    e = last_ev;
    wait_done(nt);
    checks++; if (txq.size() != nt + 1 || txq[nt] !== 8'h3F) begin errors++; $display("FAIL nak_reply: got %0d bytes want one 3f", txq.size() - nt); end
    checks++; if (wq.size() != nw || rq.size() != nr) begin errors++; $display("FAIL nak_strobes: got %0d/%0d want 0/0", wq.size() - nw, rq.size() - nr); end
    checks++; if (st_cyc != e + 1) begin errors++; $display("FAIL nak_start_lat: got %0d want 1", st_cyc - e); end
    nt = txq.size();
    send_byte(8'h52, 1); send_byte(8'h01, 1);
    wait_done(nt);
    checks++; if (rq.size() != nr + 1 || rq[nr] !== 8'h01) begin errors++; $display("FAIL nak_next_read: got %0d reads want one at 01", rq.size() - nr); end
    checks++; if (txq.size() != nt + 1 || txq[nt] !== exp_mem[8'h01]) begin errors++; $display("FAIL nak_next_reply: got %0d bytes want one %h", txq.size() - nt, exp_mem[8'h01]); end
  endtask

  task automatic test_timeout();
    int nw = wq.size(), nt = txq.size();
    send_byte(8'h57, 1); send_byte(8'h05, 1);
    repeat (TO + 10) step();
    send_byte(8'h52, 1); send_byte(8'h05, 1);
    wait_done(nt);
    checks++; if (wq.size() != nw) begin errors++; $display("FAIL timeout_no_write: got %0d writes want 0", wq.size() - nw); end
    checks++; if (txq.size() != nt + 1 || txq[nt] !== exp_mem[8'h05]) begin errors++; $display("FAIL timeout_reply: got %0d bytes want one %h", txq.size() - nt, exp_mem[8'h05]); end
  endtask

  // Byte exactly TO cycles after the previous one still belongs to the frame;
  // one cycle later the frame has been dropped and the byte opens a new one.
  task automatic test_timeout_edge();
    int nw = wq.size(), nt = txq.size(), e;
    send_byte(8'h57, 1); e = last_ev;
    wait_until(e + TO); send_byte(8'h21, 1); e = last_ev;
    wait_until(e + TO); send_byte(8'h6C, 1);
    wait_done(nt);
    exp_mem[8'h21] = 8'h6C;
    checks++; if (wq.size() != nw + 1 || wq[nw] !== 16'h216C) begin errors++; $display("FAIL edge_accept_write: got %0d writes want one 216c", wq.size() - nw); end
    checks++; if (txq.size() != nt + 1 || txq[nt] !== 8'h4B) begin errors++; $display("FAIL edge_accept_reply: got %0d bytes want one 4b", txq.size() - nt); end
    nw = wq.size(); nt = txq.size();
    send_byte(8'h57, 1); e = last_ev;
    wait_until(e + TO + 1); send_byte(8'h05, 1);
    wait_done(nt);
    checks++; if (txq.size() != nt + 1 || txq[nt] !== 8'h3F) begin errors++; $display("FAIL edge_late_reply: got %0d bytes want one 3f", txq.size() - nt); end
    checks++; if (wq.size() != nw) begin errors++; $display("FAIL edge_late_no_write: got %0d writes want 0", wq.size() - nw); end
  endtask

  task automatic test_overrun();
    int nr = rq.size(), nt = txq.size(), i = 0;
    send_byte(8'h57, 1); send_byte(8'h05, 1); send_byte(8'hA3, 1);
    exp_mem[8'h05] = 8'hA3;
    while (!tx_busy && i < 200) begin step(); i++; end
    send_byte(8'h52, 1);
    wait_done(nt);
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_flag: got %b want 1", overrun); end
    checks++; if (txq.size() != nt + 1 || txq[nt] !== 8'h4B) begin errors++; $display("FAIL ovr_reply: got %0d bytes want one 4b", txq.size() - nt); end
    checks++; if (rq.size() != nr) begin errors++; $display("FAIL ovr_ignored: got %0d reads want 0", rq.size() - nr); end
    nt = txq.size();
    send_byte(8'h52, 1); send_byte(8'h05, 1);
    wait_done(nt);
    checks++; if (txq.size() != nt + 1 || txq[nt] !== 8'hA3) begin errors++; $display("FAIL ovr_next_reply: got %0d bytes want one a3", txq.size() - nt); end
  endtask

  task automatic test_reset_mid();
    int nw, nr, nt = txq.size();
    send_byte(8'h57, 1); send_byte(8'h05, 1);
    rst = 1'b1;
    step(); step();
    checks++; if (overrun !== 1'b0 || tx_start !== 1'b0 || reg_we !== 1'b0 || reg_re !== 1'b0)
      begin errors++; $display("FAIL midrst_strobes: got ovr=%b st=%b we=%b re=%b want 0", overrun, tx_start, reg_we, reg_re); end
    checks++; if (tx_data !== 8'hFF || reg_addr !== 8'h00 || reg_wdata !== 8'h00)
      begin errors++; $display("FAIL midrst_fields: got %h/%h/%h want ff/00/00", tx_data, reg_addr, reg_wdata); end
    rst = 1'b0;
    step();
    nw = wq.size(); nr = rq.size();
    send_byte(8'h52, 1); send_byte(8'h07, 1);
    wait_done(nt);
    checks++; if (wq.size() != nw) begin errors++; $display("FAIL midrst_no_write: got %0d writes want 0", wq.size() - nw); end
    checks++; if (rq.size() != nr + 1 || rq[nr] !== 8'h07) begin errors++; $display("FAIL midrst_read: got %0d reads want one at 07", rq.size() - nr); end
    checks++; if (txq.size() != nt + 1 || txq[nt] !== exp_mem[8'h07]) begin errors++; $display("FAIL midrst_reply: got %0d bytes want one %h", txq.size() - nt, exp_mem[8'h07]); end
  endtask

  // Random frames sent back to back; the model is: W updates memory and
  // answers 4b, R answers current memory, anything else answers 3f.
  task automatic test_back_to_back();
    for (int f = 0; f < 12; f++) begin
      int kind, nw, nr, nt, ew, er;
      logic [7:0] a, d, c, exp_reply;
      kind = $urandom_range(0, 2);
      a = 8'($urandom_range(0, 255));
      d = 8'($urandom_range(0, 255));
      nw = wq.size(); nr = rq.size(); nt = txq.size();
      ew = 0; er = 0;
      if (kind == 0) begin
        send_byte(8'h57, $urandom_range(1, 3)); repeat ($urandom_range(0, 10)) step();
        send_byte(a, $urandom_range(1, 3));     repeat ($urandom_range(0, 10)) step();
        send_byte(d, $urandom_range(1, 3));
        exp_mem[a] = d; exp_reply = 8'h4B; ew = 1;
      end else if (kind == 1) begin
        send_byte(8'h52, $urandom_range(1, 3)); repeat ($urandom_range(0, 10)) step();
        send_byte(a, $urandom_range(1, 3));
        exp_reply = exp_mem[a]; er = 1;
      end else begin
        c = d;
        if (c == 8'h57 || c == 8'h52) c = c ^ 8'h01;
        send_byte(c, $urandom_range(1, 3));
        exp_reply = 8'h3F;
      end
      wait_done(nt);
      checks++; if (txq.size() != nt + 1 || txq[nt] !== exp_reply)
        begin errors++; $display("FAIL rand_reply[%0d]: got %0d bytes want one %h", f, txq.size() - nt, exp_reply); end
      checks++; if (wq.size() - nw != ew || rq.size() - nr != er)
        begin errors++; $display("FAIL rand_strobes[%0d]: got w%0d r%0d want w%0d r%0d", f, wq.size() - nw, rq.size() - nr, ew, er); end
    end
  endtask

  task automatic test_tx_protocol();
    checks++; if (viol != 0) begin errors++; $display("FAIL tx_protocol: got %0d violations want 0", viol); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) exp_mem[i] = 8'h00;
    step();
    test_reset();
    test_write();
    test_read();
    test_unknown();
    test_timeout();
    test_timeout_edge();
    test_overrun();
    test_reset_mid();
    test_back_to_back();
    test_tx_protocol();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_cmd_slave.md
# uart_cmd_slave

Byte-level command responder between the UART receiver/transmitter pair and a small register space (Mandelbrot view parameters, control bits). Parses host command frames arriving as received bytes and performs register writes or reads. Answers every complete frame with exactly one byte through the transmitter. Drops partial frames after an inter-byte timeout, so the link resynchronises without a reset.

## Interface
Parameters:
- `TIMEOUT`, default 2400000: max clocks between bytes of one frame (100 ms at 24 MHz).
- `ACK`, default 8'h4B: reply byte for a completed write ('K').
- `NAK`, default 8'h3F: reply byte for an unknown command ('?').

Ports (clock and reset first):
- `clk`  in  1  system clock, 24 MHz.
- `rst`  in  1  reset; synchronous to `clk`, active-high.
- `rx_data`  in  8  last received byte; valid while `rx_ready` is high.
- `rx_ready`  in  1  receiver byte-valid level; a new byte is signalled by its rising edge.
- `tx_data`  out  8  byte to transmit; held stable from `tx_start` until the transmitter finishes.
- `tx_start`  out  1  one-cycle transmit request.
- `tx_busy`  in  1  transmitter busy; rises the cycle after an accepted `tx_start`.
- `reg_addr`  out  8  register address.
- `reg_wdata`  out  8  write data.
- `reg_we`  out  1  one-cycle write strobe.
- `reg_re`  out  1  one-cycle read strobe.
- `reg_rdata`  in  8  read data, valid the cycle after `reg_re`.
- `overrun`  out  1  sticky flag: a byte arrived while a reply was in progress; cleared only by reset.

## Operation
- Byte event: `rx_ready` high and the registered previous `rx_ready` low. The previous-value register resets to 0.
- Frames:
  - 'W' (8'h57), addr, data: write register, reply `ACK`.
  - 'R' (8'h52), addr: read register, reply the read value.
  - Any other first byte: reply `NAK`.
- States:
  - IDLE: on an event, 'W'/'R' goes to GET_ADDR and latches the command; any other byte loads `tx_data`=`NAK` and goes to TX_START.
  - GET_ADDR: on an event, latch `reg_addr`. A 'W' command goes to GET_DATA; an 'R' command goes to DO_READ.
  - GET_DATA: on an event, latch `reg_wdata` and go to DO_WRITE.
  - DO_WRITE: `reg_we`=1 for one cycle; `tx_data`=`ACK`; then TX_START.
  - DO_READ: `reg_re`=1 for one cycle; then LATCH_RD.
  - LATCH_RD: `tx_data`=`reg_rdata`; then TX_START.
  - TX_START: `tx_start`=1 only in a cycle where `tx_busy`=0, then TX_WAIT_HI; otherwise hold.
  - TX_WAIT_HI: wait for `tx_busy`=1, then TX_WAIT_LO.
  - TX_WAIT_LO: wait for `tx_busy`=0, then IDLE.
- Timeout:
  - The counter clears on every byte event and in IDLE, and increments in GET_ADDR and GET_DATA.
  - On reaching `TIMEOUT`-1, return to IDLE with no reply and no register access.
- Events in DO_*, LATCH_RD and TX_* states are discarded and set `overrun`.
- A byte event coinciding with timeout expiry: the event wins; the byte is accepted and the counter clears.
- Reset mid-frame or mid-reply: immediate return to IDLE, partial frame discarded, no `tx_start` after reset. The transmitter completes on its own.
- Reset values: `tx_data`=8'hFF, `reg_addr`=0, `reg_wdata`=0, `tx_start`=0, `reg_we`=0, `reg_re`=0, `overrun`=0; state IDLE.

## Timing
- All outputs are registered or decoded from state with no input-to-output path. `reg_we`, `reg_re` and `tx_start` are Moore decodes.
- Byte event in cycle N is handled at the end of N: the state changes and fields latch at the N/N+1 boundary.
- Write: final data-byte event in cycle N gives `reg_we` in N+1 and `tx_start` in N+2 (with `tx_busy`=0).
- Read: address-byte event in cycle N gives `reg_re` in N+1, `reg_rdata` sampled in N+2, and `tx_start` in N+3.
- NAK: event in N gives `tx_start` in N+1.
- The next frame is accepted from the first cycle after `tx_busy` falls; the reply lasts 10 bit times.
- Timeout counter is `$clog2(TIMEOUT)` bits wide; no wrap occurs because it is bounded by the compare.

## Structure
- Shared package `uart_pkg`: command byte constants (`CMD_W`, `CMD_R`), default `ACK`/`NAK`, the clock/baud `DIV` constant, and the state enum.
- No sub-module; a single FSM with the edge detector and timeout counter inline. Instantiated alongside the existing receiver and transmitter in the top level.

## Test plan
- Write: bytes 57,05,A3 -> one `reg_we` pulse with addr 05, data A3; transmitter sends 4B; `overrun`=0.
- Read: bytes 52,05 with the model returning A3 -> one `reg_re` pulse at addr 05; transmitter sends A3; no `reg_we`.
- Unknown command: byte 00 -> transmitter sends 3F; no register strobes; next frame 52,01 is handled normally.
- Timeout: 57,05, then idle for `TIMEOUT`+10 clocks, then 52,05 -> no write, a single read reply.
- Overrun: after 57,05,A3, send 52 during the ACK reply -> byte ignored, `overrun`=1, FSM back in IDLE after `tx_busy` falls.
- Reset: assert `rst` after 57,05, release, then 52,07 -> only the read occurs; all outputs at their reset values during `rst`.
